// File: rtl/pdp_rdma_layer_ctrl.sv
// rtl/pdp_rdma_layer_ctrl.sv - PDP RDMA consumer-side ping-pong layer sequencer
module pdp_rdma_layer_ctrl #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       grp0_op_en_set,
    input  logic       grp1_op_en_set,
    input  logic       dp_done,
    output logic       consumer,
    output logic [1:0] status_0,
    output logic [1:0] status_1,
    output logic       grp0_op_en,
    output logic       grp1_op_en,
    output logic       dp_start,
    output logic       dp_op_en,
    output logic       dp_grp,
    output logic [1:0] intr_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    // Gap counter reload; with no gap the counter is never used.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_consumer;
    logic [1:0] r_op_en;
    logic [1:0] w_op_en_nxt;
    logic [3:0] r_gap_cnt;
    logic       r_dp_start;
    logic [1:0] r_intr_done;
    logic       w_launch;
    logic       w_retire;

    // A layer launches only for the consumer group; done is ignored outside BUSY.
    assign w_launch = (r_state == S_IDLE) && r_op_en[r_consumer];
    assign w_retire = (r_state == S_BUSY) && dp_done;

    // A set pulse wins over retirement so a same-cycle re-arm leaves op_en high.
    always_comb begin
        w_op_en_nxt    = r_op_en;
        w_op_en_nxt[0] = grp0_op_en_set | (r_op_en[0] & ~(w_retire & ~r_consumer));
        w_op_en_nxt[1] = grp1_op_en_set | (r_op_en[1] & ~(w_retire &  r_consumer));
    end

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> BUSY on launch, BUSY -> GAP/IDLE on done, GAP drains.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dp_done) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pointer, op_en bits, gap counter and the registered start/interrupt pulses.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_consumer  <= 1'b0;
            r_op_en     <= 2'b00;
            r_gap_cnt   <= 4'd0;
            r_dp_start  <= 1'b0;
            r_intr_done <= 2'b00;
        end else begin
            r_op_en    <= w_op_en_nxt;
            r_dp_start <= w_launch;
            if (w_retire) begin
                r_consumer  <= ~r_consumer;
                r_gap_cnt   <= GAP_LOAD;
                r_intr_done <= r_consumer ? 2'b10 : 2'b01;
            end else begin
                r_intr_done <= 2'b00;
                if ((r_state == S_GAP) && (r_gap_cnt != 4'd0)) begin
                    r_gap_cnt <= r_gap_cnt - 4'd1;
                end
            end
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
        consumer   = r_consumer;
        dp_grp     = r_consumer;
        grp0_op_en = r_op_en[0];
        grp1_op_en = r_op_en[1];
        dp_start   = r_dp_start;
        dp_op_en   = (r_state == S_BUSY);
        intr_done  = r_intr_done;
        status_0   = ST_IDLE;
        status_1   = ST_IDLE;
        if (r_op_en[0]) begin
            status_0 = ((r_state == S_BUSY) && !r_consumer) ? ST_RUNNING : ST_PENDING;
        end
        if (r_op_en[1]) begin
            status_1 = ((r_state == S_BUSY) && r_consumer) ? ST_RUNNING : ST_PENDING;
        end
    end

endmodule

// File: tb/tb_pdp_rdma_layer_ctrl.sv
// tb/tb_pdp_rdma_layer_ctrl.sv - scoreboard bench for pdp_rdma_layer_ctrl
module tb_pdp_rdma_layer_ctrl;

    logic       nvdla_core_clk = 1'b0;
    logic       nvdla_core_rstn = 1'b0;
    logic       grp0_op_en_set = 1'b0;
    logic       grp1_op_en_set = 1'b0;
    logic       dp_done = 1'b0;
    logic       consumer;
    logic [1:0] status_0;
    logic [1:0] status_1;
    logic       grp0_op_en;
    logic       grp1_op_en;
    logic       dp_start;
    logic       dp_op_en;
    logic       dp_grp;
    logic [1:0] intr_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        bit is_done;
        bit grp;
        int cyc;
    } ev_t;

    ev_t q_exp[$];

    pdp_rdma_layer_ctrl #(.GAP_CYCLES(1)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .grp0_op_en_set  (grp0_op_en_set),
        .grp1_op_en_set  (grp1_op_en_set),
        .dp_done         (dp_done),
        .consumer        (consumer),
        .status_0        (status_0),
        .status_1        (status_1),
        .grp0_op_en      (grp0_op_en),
        .grp1_op_en      (grp1_op_en),
        .dp_start        (dp_start),
        .dp_op_en        (dp_op_en),
        .dp_grp          (dp_grp),
        .intr_done       (intr_done)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    always @(posedge nvdla_core_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input bit is_done, input bit grp, input int at);
        ev_t e;
        e.is_done = is_done;
        e.grp     = grp;
        e.cyc     = at;
        q_exp.push_back(e);
    endfunction

    // Monitor: every start/interrupt pulse is matched against the next expected event.
    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            if (intr_done != 2'b00) begin
                if (q_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_intr_done: got %0d expected none (cycle %0d)", intr_done, cyc);
                end else begin
                    ev_t e;
                    e = q_exp.pop_front();
                    chk("event_is_done", 1, int'(e.is_done));
                    chk("intr_done_val", int'(intr_done), e.grp ? 2 : 1);
                    chk("intr_done_cycle", cyc, e.cyc);
                end
            end
            if (dp_start) begin
                if (q_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_dp_start: got grp %0d expected none (cycle %0d)", dp_grp, cyc);
                end else begin
                    ev_t e;
                    e = q_exp.pop_front();
                    chk("event_is_start", 0, int'(e.is_done));
                    chk("dp_start_grp", int'(dp_grp), int'(e.grp));
                    chk("dp_start_cycle", cyc, e.cyc);
                    chk("dp_start_op_en", int'(dp_op_en), 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge nvdla_core_clk);
            #1;
        end
    endtask

    task automatic drive(input logic s0, input logic s1, input logic d);
        grp0_op_en_set = s0;
        grp1_op_en_set = s1;
        dp_done        = d;
        tick(1);
        grp0_op_en_set = 1'b0;
        grp1_op_en_set = 1'b0;
        dp_done        = 1'b0;
    endtask

    task automatic do_reset();
        nvdla_core_rstn = 1'b0;
        grp0_op_en_set  = 1'b0;
        grp1_op_en_set  = 1'b0;
        dp_done         = 1'b0;
        tick(3);
        nvdla_core_rstn = 1'b1;
        tick(1);
    endtask

    initial begin
        int n;
        int m;

        // Reset state and a single group 0 layer.
        do_reset();
        chk("rst_consumer", int'(consumer), 0);
        chk("rst_status_0", int'(status_0), 0);
        chk("rst_status_1", int'(status_1), 0);
        chk("rst_op_en", int'({grp1_op_en, grp0_op_en}), 0);
        chk("rst_dp_op_en", int'(dp_op_en), 0);
        chk("rst_dp_grp", int'(dp_grp), 0);
        tick(2);
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        chk("t1_pending_status_0", int'(status_0), 2);
        chk("t1_grp0_op_en", int'(grp0_op_en), 1);
        tick(1);
        chk("t1_running_status_0", int'(status_0), 1);
        chk("t1_status_1", int'(status_1), 0);
        chk("t1_dp_op_en", int'(dp_op_en), 1);
        tick(10);
        m = cyc;
        push_ev(1, 0, m + 1);
        drive(0, 0, 1);
        chk("t1_consumer_after", int'(consumer), 1);
        chk("t1_status_0_after", int'(status_0), 0);
        chk("t1_grp0_op_en_after", int'(grp0_op_en), 0);
        chk("t1_dp_op_en_after", int'(dp_op_en), 0);
        tick(5);

        // Ping-pong: both groups armed together.
        do_reset();
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 1, 0);
        tick(1);
        chk("t2_status_0_run", int'(status_0), 1);
        chk("t2_status_1_pend", int'(status_1), 2);
        chk("t2_grp1_op_en", int'(grp1_op_en), 1);
        tick(6);
        m = cyc;
        push_ev(1, 0, m + 1);
        push_ev(0, 1, m + 3);
        drive(0, 0, 1);
        chk("t2_gap_dp_op_en", int'(dp_op_en), 0);
        chk("t2_gap_status_1", int'(status_1), 2);
        tick(2);
        chk("t2_dp_grp_1", int'(dp_grp), 1);
        chk("t2_status_1_run", int'(status_1), 1);
        tick(5);
        m = cyc;
        push_ev(1, 1, m + 1);
        drive(0, 0, 1);
        chk("t2_consumer_back", int'(consumer), 0);
        chk("t2_status_1_done", int'(status_1), 0);
        tick(5);

        // Out-of-order arm: group 1 waits for group 0.
        do_reset();
        drive(0, 1, 0);
        tick(50);
        chk("t3_status_1_pend", int'(status_1), 2);
        chk("t3_grp1_op_en", int'(grp1_op_en), 1);
        chk("t3_no_launch", int'(dp_op_en), 0);
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        tick(1);
        chk("t3_dp_grp_0", int'(dp_grp), 0);
        tick(4);
        m = cyc;
        push_ev(1, 0, m + 1);
        push_ev(0, 1, m + 3);
        drive(0, 0, 1);
        tick(6);
        m = cyc;
        push_ev(1, 1, m + 1);
        drive(0, 0, 1);
        tick(5);

        // Re-arm coinciding with retirement.
        do_reset();
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        tick(5);
        m = cyc;
        push_ev(1, 0, m + 1);
        drive(1, 0, 1);
        chk("t4_grp0_op_en_kept", int'(grp0_op_en), 1);
        chk("t4_status_0_pend", int'(status_0), 2);
        chk("t4_consumer", int'(consumer), 1);
        tick(10);
        n = cyc;
        push_ev(0, 1, n + 2);
        drive(0, 1, 0);
        tick(5);
        m = cyc;
        push_ev(1, 1, m + 1);
        push_ev(0, 0, m + 3);
        drive(0, 0, 1);
        tick(6);
        m = cyc;
        push_ev(1, 0, m + 1);
        drive(0, 0, 1);
        chk("t4_grp0_op_en_final", int'(grp0_op_en), 0);
        tick(5);

        // Spurious done while idle and duplicate set while running.
        do_reset();
        drive(0, 0, 1);
        chk("t5_spurious_consumer", int'(consumer), 0);
        chk("t5_spurious_status_0", int'(status_0), 0);
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        tick(3);
        drive(1, 0, 0);
        chk("t5_dup_status_0", int'(status_0), 1);
        tick(3);
        m = cyc;
        push_ev(1, 0, m + 1);
        drive(0, 0, 1);
        tick(20);
        chk("t5_no_extra_op_en", int'(grp0_op_en), 0);
        chk("t5_no_extra_busy", int'(dp_op_en), 0);

        // Reset mid-layer.
        do_reset();
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        tick(3);
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_rst_dp_op_en", int'(dp_op_en), 0);
        chk("t6_rst_grp0_op_en", int'(grp0_op_en), 0);
        chk("t6_rst_status_0", int'(status_0), 0);
        chk("t6_rst_dp_start", int'(dp_start), 0);
        chk("t6_rst_intr_done", int'(intr_done), 0);
        chk("t6_rst_consumer", int'(consumer), 0);
        tick(2);
        nvdla_core_rstn = 1'b1;
        tick(20);
        chk("t6_idle_after_rst", int'(dp_op_en), 0);
        n = cyc;
        push_ev(0, 0, n + 2);
        drive(1, 0, 0);
        tick(4);
        m = cyc;
        push_ev(1, 0, m + 1);
        drive(0, 0, 1);
        tick(4);

        chk("scoreboard_drained", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pdp_rdma_layer_ctrl.md
# pdp_rdma_layer_ctrl

Consumer-side layer sequencer for the PDP RDMA dual register groups. Software programs a group selected by the `producer` pointer and arms it with an op_en write. This block then owns the other end of the pointer pair: it tracks which group the datapath consumes, launches and retires layers in ping-pong order, and drives the `consumer`, `status_0` and `status_1` read-only fields back into the single register block. It sits between the register top level and the RDMA read engine.

## Interface
- GAP_CYCLES, 1, idle cycles inserted after a layer retires before the next launch; legal range 0..15.
- nvdla_core_clk  input  1  core clock.
- nvdla_core_rstn  input  1  reset: asynchronous, active-low; clock nvdla_core_clk.
- grp0_op_en_set  input  1  one-cycle pulse; software wrote op_en=1 to group 0.
- grp1_op_en_set  input  1  one-cycle pulse; software wrote op_en=1 to group 1.
- dp_done  input  1  one-cycle pulse from the read engine; active layer finished.
- consumer  output  1  group currently owned or next to be owned by the datapath.
- status_0  output  2  group 0 status: 0=IDLE, 1=RUNNING, 2=PENDING.
- status_1  output  2  group 1 status, same encoding.
- grp0_op_en  output  1  op_en readback for group 0.
- grp1_op_en  output  1  op_en readback for group 1.
- dp_start  output  1  one-cycle pulse when a layer is launched.
- dp_op_en  output  1  level; high while a layer is active.
- dp_grp  output  1  register group the active layer uses; equals `consumer`.
- intr_done  output  2  one-cycle pulse; bit g fires when group g retires.

## Operation
- **op_en[g] register**
  - Set on grpg_op_en_set.
  - Cleared when the group retires.
  - A set that arrives while op_en[g] is already 1 is ignored, unless it coincides with retirement of g; see boundaries.
- **FSM states: IDLE, BUSY, GAP.**
  - IDLE: if op_en[consumer]==1, go to BUSY and pulse dp_start.
  - BUSY: dp_op_en=1. On dp_done:
    - clear op_en[consumer];
    - pulse intr_done[consumer];
    - toggle consumer;
    - go to GAP with gap_cnt=GAP_CYCLES-1, or go straight to IDLE if GAP_CYCLES==0.
  - GAP: decrement gap_cnt each cycle; at 0, go to IDLE.
- **Status for group g**
  - 0 if op_en[g]==0.
  - Else 1 if state==BUSY and consumer==g.
  - Else 2.
- **Ordering**
  - Strict ping-pong: the datapath never skips the consumer group.
  - Group 1 armed while consumer==0 and op_en[0]==0 stays PENDING until group 0 is armed and retired.
- **Boundaries**
  - dp_done outside BUSY: ignored.
  - Set and retire of the same group in the same cycle: op_en[g] ends 1 (re-armed), status 2, intr_done still pulses.
  - Both set pulses in the same cycle: both op_en bits set.
  - Reset mid-layer: everything returns to reset values immediately; no intr_done, no further dp_start.

## Timing
- **Reset values:** consumer=0, status_0=status_1=0, grp0_op_en=grp1_op_en=0, dp_start=0, dp_op_en=0, dp_grp=0, intr_done=0, state=IDLE, gap_cnt=0.
- All outputs are registered or decoded from registers only; there is no input-to-output combinational path.
- **Launch latency**
  - A set pulse sampled at edge N makes op_en visible after N.
  - With the FSM in IDLE and matching consumer, dp_start and dp_op_en rise after edge N+1.
- **Retire latency**
  - dp_done sampled at edge M: dp_op_en falls, intr_done pulses, consumer toggles and op_en clears, all after M.
  - The next dp_start occurs after edge M+GAP_CYCLES+1 at the earliest.
  - With GAP_CYCLES=0 this is back-to-back plus one IDLE cycle.
- dp_start is exactly one cycle wide and coincides with the first BUSY cycle.

## Test plan
- **Reset and single layer:** release reset, pulse grp0_op_en_set at cycle 5.
  - dp_start at cycle 7; status_0 reads 1; status_1 reads 0.
  - dp_done at cycle 20: intr_done=2'b01 at cycle 21, consumer=1, status_0=0.
- **Ping-pong back-to-back:** arm group 0 and group 1 in the same cycle with GAP_CYCLES=1.
  - Group 0 runs; status_1=2.
  - dp_done at T: group 1's dp_start at T+3, dp_grp=1.
  - After its done, consumer=0.
- **Out-of-order arm:** arm only group 1 while consumer=0.
  - No dp_start for 50 cycles; status_1=2.
  - Arm group 0: group 0 launches first.
- **Re-arm on retire:** pulse grp0_op_en_set in the same cycle as dp_done for group 0.
  - intr_done[0] pulses; grp0_op_en stays 1; status_0=2.
  - Group 0 runs again after group 1 when group 1 is armed.
- **Spurious done and duplicate set:** dp_done while IDLE changes nothing; a second grp0_op_en_set while group 0 is RUNNING causes no extra layer after retire.
- **Reset mid-layer:** assert nvdla_core_rstn low during BUSY.
  - All outputs go to 0 asynchronously.
  - After release, there is no dp_start until a new set pulse.
